reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//  Parametrised register file for the simple processor datapath: DEPTH x DATA_WIDTH, two
//  combinational read ports, one clocked write port. Adds optional write-to-read bypass,
//  optional hard-wired zero register, and a per-register pending (scoreboard) bit, so the
//  control unit can stall on a register awaiting a multi-cycle result.
// PARAMETERS
//  DATA_WIDTH  8  register width in bits
//  ADDR_WIDTH  3  register address width; DEPTH = 2**ADDR_WIDTH
//  BYPASS      1  1: a same-cycle write is forwarded to matching read ports; 0: no forwarding
//  ZERO_REG    0  1: register 0 always reads 0; writes and reserves to it are ignored
// PORTS
//  CLK          in   1           clock; all state updates on rising edge
//  RESET        in   1           asynchronous, active-high reset
//  WRITEENABLE  in   1           write strobe, sampled at rising CLK
//  WRITEREG     in   ADDR_WIDTH  write address
//  WRITEDATA    in   DATA_WIDTH  write data
//  READREG1     in   ADDR_WIDTH  read port 1 address
//  READREG2     in   ADDR_WIDTH  read port 2 address
//  RESERVE      in   1           set pending bit of RESERVEREG at rising CLK
//  RESERVEREG   in   ADDR_WIDTH  register to mark pending
//  REGOUT1      out  DATA_WIDTH  read port 1 data
//  REGOUT2      out  DATA_WIDTH  read port 2 data
//  BUSY1        out  1           READREG1 holds a pending (not yet written) value
//  BUSY2        out  1           READREG2 holds a pending value
// BEHAVIOUR
//  Reset: while RESET=1, all registers and pending bits clear to 0 immediately, independent of
//   CLK. REGOUT1/2 = 0 and BUSY1/2 = 0 for any address. WRITEENABLE/RESERVE are ignored
//   during reset. Deassertion takes effect from the next rising edge.
//  Write: at rising CLK with WRITEENABLE=1, regs[WRITEREG] <= WRITEDATA.
//   The written value is visible on a non-bypassed read immediately after that edge.
//  Read: REGOUTn = regs[READREGn], combinational, with zero clock latency.
//  Bypass (BYPASS=1): if WRITEENABLE=1 and WRITEREG==READREGn, REGOUTn = WRITEDATA in the
//   same cycle, before the edge. Both ports may bypass at once.
//  Pending: the write at rising CLK clears pending[WRITEREG]. RESERVE=1 sets
//   pending[RESERVEREG]. If both target the same register on the same edge, the reserve wins
//   and the bit stays 1: a new producer has claimed the register.
//  BUSYn = pending[READREGn], except BUSYn = 0 when BYPASS=1 and a bypass hit exists on port n
//   this cycle, because the value is being delivered.
//  ZERO_REG=1: reads of address 0 return 0 and BUSYn=0. Writes and reserves to address 0 have
//   no effect, and there is no bypass from address 0.
//  Addresses are full-range: every value of an ADDR_WIDTH-bit address is valid. There is no
//   wrap and no out-of-range case.
//  READREG1==READREG2 is legal; both ports return identical data and busy flags.
//  RESET asserted mid-write: the reset wins and the register reads 0 after the edge.
// TESTING
//  1 Reset: pulse RESET asynchronously (between edges), then read all 8 addresses
//    -> every REGOUT = 0, BUSY = 0; the clear is seen before the next CLK edge.
//  2 Write/read: write 95 to r2, 28 to r1 on separate edges; READREG1=2, READREG2=1
//    -> REGOUT1=95, REGOUT2=28. Keep WRITEENABLE=0 for 3 cycles -> values hold.
//  3 Bypass: r4=6; WRITEENABLE=1, WRITEREG=4, WRITEDATA=15, READREG1=4 before the edge
//    -> REGOUT1=15 pre-edge with BYPASS=1. With BYPASS=0, REGOUT1=6 pre-edge, then 15 post-edge.
//  4 Scoreboard: RESERVE r3 -> BUSY1=1 for READREG1=3. Write r3=50 -> BUSY1=0 after the edge
//    (0 during the write cycle if BYPASS=1). Reserve and write r3 on the same edge -> BUSY1=1.
//  5 Zero reg (ZERO_REG=1): write 50 to r0 and reserve r0 -> REGOUT1=0 and BUSY1=0 for
//    READREG1=0. Write 50 to r7 -> reads 50, proving the upper address works.
//  6 Reset mid-operation: r1=28 pending; assert RESET coincident with a write of 9 to r1
//    -> REGOUT=0, BUSY=0. After release, a fresh write of 9 to r1 reads 9.

Source files
------------

// File: rtl/reg_file_param.sv
// DEPTH x DATA_WIDTH register file: two combinational read ports, one clocked write port,
// optional write-to-read bypass, optional hard-wired zero register, per-register pending bits.
module reg_file_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WRITEENABLE,
    input  logic [ADDR_WIDTH-1:0] WRITEREG,
    input  logic [DATA_WIDTH-1:0] WRITEDATA,
    input  logic [ADDR_WIDTH-1:0] READREG1,
    input  logic [ADDR_WIDTH-1:0] READREG2,
    input  logic                  RESERVE,
    input  logic [ADDR_WIDTH-1:0] RESERVEREG,
    output logic [DATA_WIDTH-1:0] REGOUT1,
    output logic [DATA_WIDTH-1:0] REGOUT2,
    output logic                  BUSY1,
    output logic                  BUSY2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      pending_nxt;

    logic write_ok;
    logic reserve_ok;
    logic zero1;
    logic zero2;
    logic hit1;
    logic hit2;

    // With a hard-wired zero register, address 0 silently absorbs writes and reserves.
    assign write_ok   = WRITEENABLE && !((ZERO_REG != 0) && (WRITEREG == '0));
    assign reserve_ok = RESERVE && !((ZERO_REG != 0) && (RESERVEREG == '0));

    assign zero1 = (ZERO_REG != 0) && (READREG1 == '0);
    assign zero2 = (ZERO_REG != 0) && (READREG2 == '0);
    assign hit1  = (BYPASS != 0) && write_ok && (WRITEREG == READREG1);
    assign hit2  = (BYPASS != 0) && write_ok && (WRITEREG == READREG2);

    // Reset also masks the bypass path so outputs read 0 for the whole reset window.
    assign REGOUT1 = (RESET || zero1) ? '0 : (hit1 ? WRITEDATA : regs[READREG1]);
    assign REGOUT2 = (RESET || zero2) ? '0 : (hit2 ? WRITEDATA : regs[READREG2]);
    assign BUSY1   = !(RESET || zero1 || hit1) && pending[READREG1];
    assign BUSY2   = !(RESET || zero2 || hit2) && pending[READREG2];

    // Reserve is applied after the write clear so a new producer's claim wins.
    always_comb begin
        pending_nxt = pending;
        if (write_ok) begin
            pending_nxt[WRITEREG] = 1'b0;
        end
        if (reserve_ok) begin
            pending_nxt[RESERVEREG] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else begin
            if (write_ok) begin
                regs[WRITEREG] <= WRITEDATA;
            end
            pending <= pending_nxt;
        end
    end
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two instances (bypass/no-zero and no-bypass/zero-reg) share stimulus;
// expectations come from an array-based reference model through a scoreboard queue.
module tb_reg_file_param;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       WRITEENABLE;
    logic [2:0] WRITEREG;
    logic [7:0] WRITEDATA;
    logic [2:0] READREG1;
    logic [2:0] READREG2;
    logic       RESERVE;
    logic [2:0] RESERVEREG;

    logic [7:0] out1_a, out2_a, out1_b, out2_b;
    logic       busy1_a, busy2_a, busy1_b, busy2_b;

    always #5 CLK = ~CLK;

    reg_file_param dut_a (
        .CLK(CLK), .RESET(RESET), .WRITEENABLE(WRITEENABLE), .WRITEREG(WRITEREG),
        .WRITEDATA(WRITEDATA), .READREG1(READREG1), .READREG2(READREG2),
        .RESERVE(RESERVE), .RESERVEREG(RESERVEREG),
        .REGOUT1(out1_a), .REGOUT2(out2_a), .BUSY1(busy1_a), .BUSY2(busy2_a)
    );

    reg_file_param #(.BYPASS(0), .ZERO_REG(1)) dut_b (
        .CLK(CLK), .RESET(RESET), .WRITEENABLE(WRITEENABLE), .WRITEREG(WRITEREG),
        .WRITEDATA(WRITEDATA), .READREG1(READREG1), .READREG2(READREG2),
        .RESERVE(RESERVE), .RESERVEREG(RESERVEREG),
        .REGOUT1(out1_b), .REGOUT2(out2_b), .BUSY1(busy1_b), .BUSY2(busy2_b)
    );

    typedef struct {
        logic [3:0][7:0] data;
        logic [3:0]      busy;
        string           tag;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    // Reference state: index 0 models dut_a, index 1 models dut_b.
    logic [7:0] mreg  [2][8];
    logic       mpend [2][8];

    function automatic void model_clear();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 8; r++) begin
                mreg[c][r]  = 8'd0;
                mpend[c][r] = 1'b0;
            end
    endfunction

    function automatic void model_read(input int c, input logic [2:0] a,
                                       output logic [7:0] d, output logic b);
        bit bypass_on = (c == 0);
        bit zero_on   = (c == 1);
        if (RESET || (zero_on && a == 3'd0)) begin
            d = 8'd0; b = 1'b0;
        end else if (bypass_on && WRITEENABLE && WRITEREG == a) begin
            d = WRITEDATA; b = 1'b0;
        end else begin
            d = mreg[c][a]; b = mpend[c][a];
        end
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < 2; c++) begin
            bit zero_on = (c == 1);
            if (WRITEENABLE && !(zero_on && WRITEREG == 3'd0)) begin
                mreg[c][WRITEREG]  = WRITEDATA;
                mpend[c][WRITEREG] = 1'b0;
            end
            if (RESERVE && !(zero_on && RESERVEREG == 3'd0))
                mpend[c][RESERVEREG] = 1'b1;
        end
    endfunction

    task automatic step(input string tag, input logic we, input logic [2:0] wa,
                        input logic [7:0] wd, input logic [2:0] r1, input logic [2:0] r2,
                        input logic res, input logic [2:0] rr, input logic rst,
                        input logic pulse);
        exp_t e;
        WRITEENABLE = we; WRITEREG = wa; WRITEDATA = wd;
        READREG1 = r1; READREG2 = r2; RESERVE = res; RESERVEREG = rr;
        RESET = rst;
        if (pulse) begin
            // Reset pulse entirely between clock edges.
            RESET = 1'b1;
            #2;
            RESET = 1'b0;
            model_clear();
        end
        if (RESET) model_clear();
        for (int c = 0; c < 2; c++) begin
            model_read(c, r1, e.data[2*c],   e.busy[2*c]);
            model_read(c, r2, e.data[2*c+1], e.busy[2*c+1]);
        end
        e.tag = tag;
        sb.push_back(e);
        if (!RESET) model_edge();
        @(posedge CLK);
        #1;
    endtask

    function automatic void check(input string tag, input int k, input logic [7:0] act,
                                  input logic [7:0] exp_v, input string what);
        total++;
        if (act !== exp_v)
            $display("FAIL %s %s[%0d] got %0d expected %0d", tag, what, k, act, exp_v);
        else
            passed++;
    endfunction

    // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [3:0][7:0] ad;
            logic [3:0]      ab;
            e  = sb.pop_front();
            ad = {out2_b, out1_b, out2_a, out1_a};
            ab = {busy2_b, busy1_b, busy2_a, busy1_a};
            for (int k = 0; k < 4; k++) begin
                check(e.tag, k, ad[k], e.data[k], "data");
                check(e.tag, k, {7'd0, ab[k]}, {7'd0, e.busy[k]}, "busy");
            end
        end
    end

    initial begin
        RESET = 1'b1; WRITEENABLE = 1'b0; WRITEREG = '0; WRITEDATA = '0;
        READREG1 = '0; READREG2 = '0; RESERVE = 1'b0; RESERVEREG = '0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        step("reset_hold", 0, 0, 0, 3, 6, 0, 0, 1, 0);

        // Write/read and hold
        step("wr_r2", 1, 2, 95, 2, 1, 0, 0, 0, 0);
        step("wr_r1", 1, 1, 28, 2, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("hold", 0, 0, 0, 2, 1, 0, 0, 0, 0);

        // Async reset pulse between edges, then sweep every address
        step("pre_pulse", 1, 7, 200, 2, 7, 1, 5, 0, 0);
        step("pulse", 0, 0, 0, 2, 5, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step("sweep", 0, 0, 0, 3'(i), 3'(7 - i), 0, 0, 0, 0);

        // Bypass
        step("wr_r4", 1, 4, 6, 0, 0, 0, 0, 0, 0);
        step("bypass", 1, 4, 15, 4, 4, 0, 0, 0, 0);
        step("post_byp", 0, 0, 0, 4, 3, 0, 0, 0, 0);

        // Scoreboard
        step("rsv_r3", 0, 0, 0, 3, 4, 1, 3, 0, 0);
        step("busy_r3", 1, 3, 50, 3, 3, 0, 0, 0, 0);
        step("clr_r3", 1, 3, 51, 3, 2, 1, 3, 0, 0);
        step("rsv_wins", 0, 0, 0, 3, 3, 0, 0, 0, 0);

        // Zero register and top address
        step("wr_r0", 1, 0, 50, 0, 7, 1, 0, 0, 0);
        step("rd_r0", 1, 7, 50, 0, 7, 0, 0, 0, 0);
        step("rd_r7", 0, 0, 0, 0, 7, 0, 0, 0, 0);

        // Reset mid-write
        step("wr_r1b", 1, 1, 28, 1, 1, 1, 1, 0, 0);
        step("rst_wr", 1, 1, 9, 1, 1, 0, 0, 1, 0);
        step("after_rst", 1, 1, 9, 1, 2, 0, 0, 0, 0);
        step("rd_r1", 0, 0, 0, 1, 1, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                 3'($urandom), 3'($urandom), 1'($urandom_range(0, 2) == 0), 3'($urandom),
                 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 79) == 0));

        repeat (2) @(negedge CLK);
        total++;
        if (sb.size() != 0)
            $display("FAIL drain queue left %0d expected 0", sb.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
